// File: rtl/expr_tx.sv
// rtl/expr_tx.sv - serializes BCD operands and +/* operators as an ASCII stream
// and returns the left-to-right evaluated 8-bit result.
module expr_tx #(
  parameter int MAXTERMS = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [3:0]              nterms,
  input  logic [4*MAXTERMS-1:0]   digits,
  input  logic [MAXTERMS-2:0]     ops,
  output logic [7:0]              out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              res
);

  typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

  state_t                  state_q, state_d;
  logic [4*MAXTERMS-1:0]   digits_q, digits_d;
  logic [MAXTERMS-2:0]     ops_q, ops_d;
  logic [3:0]              nterms_q, nterms_d;
  logic [3:0]              idx_q, idx_d;
  logic [7:0]              acc_q, acc_d;
  logic [7:0]              out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [7:0]              res_q, res_d;

  logic [3:0] cur_digit, next_digit;
  logic       cur_op, prev_op;
  logic       start_bad;
  logic [7:0] acc_next;
  logic       xfer;

  // Operand/operator selection by the running term index.
  always_comb begin
    cur_digit  = 4'd0;
    next_digit = 4'd0;
    cur_op     = 1'b0;
    prev_op    = 1'b0;
    for (int i = 0; i < MAXTERMS; i++) begin
      if (idx_q == 4'(i))         cur_digit  = digits_q[4*i +: 4];
      if (idx_q + 4'd1 == 4'(i))  next_digit = digits_q[4*i +: 4];
    end
    for (int i = 0; i < MAXTERMS - 1; i++) begin
      if (idx_q == 4'(i))     cur_op  = ops_q[i];
      if (idx_q == 4'(i + 1)) prev_op = ops_q[i];
    end
  end

  // Only terms that are actually part of the frame must be valid BCD.
  always_comb begin
    start_bad = (nterms == 4'd0) || (nterms > 4'(MAXTERMS));
    for (int i = 0; i < MAXTERMS; i++) begin
      if ((4'(i) < nterms) && (digits[4*i +: 4] > 4'd9)) start_bad = 1'b1;
    end
  end

  always_comb begin
    if (idx_q == 4'd0)
      acc_next = {4'd0, cur_digit};
    else if (prev_op)
      acc_next = 8'(acc_q * {4'd0, cur_digit});
    else
      acc_next = acc_q + {4'd0, cur_digit};
  end

  assign xfer = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    ops_d       = ops_q;
    nterms_d    = nterms_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    res_d       = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            digits_d    = digits;
            ops_d       = ops;
            nterms_d    = nterms;
            idx_d       = 4'd0;
            out_d       = 8'h30 + {4'd0, digits[3:0]};
            out_valid_d = 1'b1;
            last_d      = (nterms == 4'd1);
            busy_d      = 1'b1;
            state_d     = DIGIT;
          end
        end
      end
      DIGIT: begin
        if (xfer) begin
          acc_d = acc_next;
          if (idx_q == nterms_q - 4'd1) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            res_d       = acc_next;
            state_d     = IDLE;
          end else begin
            out_d   = cur_op ? 8'h2A : 8'h2B;
            last_d  = 1'b0;
            state_d = OP;
          end
        end
      end
      OP: begin
        if (xfer) begin
          idx_d   = idx_q + 4'd1;
          out_d   = 8'h30 + {4'd0, next_digit};
          last_d  = (idx_q + 4'd1 == nterms_q - 4'd1);
          state_d = DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      ops_q       <= '0;
      nterms_q    <= 4'd0;
      idx_q       <= 4'd0;
      acc_q       <= 8'h00;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      ops_q       <= ops_d;
      nterms_q    <= nterms_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      res_q       <= res_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign res       = res_q;

endmodule

// File: tb/tb_expr_tx.sv
// tb/tb_expr_tx.sv - directed bench for expr_tx: framing, backpressure,
// wrap-around, rejection and mid-frame clear.
module tb_expr_tx;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  nterms;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic        last;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  res;

  int checks = 0;
  int errors = 0;

  expr_tx #(.MAXTERMS(8)) dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .digits(digits),
    .ops(ops), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .last(last), .busy(busy), .done(done), .err(err), .res(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input logic [31:0] dg, input logic [6:0] op,
                           input logic [7:0] exp_res, input bit bp, input string name);
    int idx;
    int cyc;
    bit held;
    logic [7:0] held_val;
    logic [7:0] exp_ch;
    logic rdy;
    nterms = 4'(n); digits = dg; ops = op; start = 1'b1;
    tick();
    start = 1'b0;
    digits = 32'hFFFF_FFFF; ops = 7'h7F; nterms = 4'd0;
    chk({name, "_busy"}, busy, 1);
    idx = 0; cyc = 0; held = 0; held_val = 8'h00;
    while (idx < 2*n - 1 && cyc < 200) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      chk({name, "_valid"}, out_valid, 1);
      if (held) chk({name, "_hold"}, out, held_val);
      if (rdy) begin
        if (idx % 2 == 0) exp_ch = 8'h30 + {4'd0, dg[4*(idx/2) +: 4]};
        else              exp_ch = op[idx/2] ? 8'h2A : 8'h2B;
        chk({name, "_char"}, out, exp_ch);
        chk({name, "_last"}, last, (idx == 2*n - 2));
        idx++;
        held = 0;
      end else begin
        held = 1;
        held_val = out;
      end
      tick();
      cyc++;
    end
    if (cyc >= 200) chk({name, "_timeout"}, 0, 1);
    if (!bp) chk({name, "_cycles"}, cyc, 2*n - 1);
    out_ready = 1'b1;
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_valid_end"}, out_valid, 0);
    chk({name, "_res"}, res, exp_res);
  endtask

  task automatic reject(input int n, input logic [31:0] dg, input logic [7:0] exp_res,
                        input string name);
    nterms = 4'(n); digits = dg; ops = 7'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_err"}, err, 1);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_res"}, res, exp_res);
    tick();
    chk({name, "_err_pulse"}, err, 0);
    chk({name, "_valid2"}, out_valid, 0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; nterms = 4'd0; digits = 32'h0; ops = 7'h0; out_ready = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_out", out, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", res, 8'h00);

    run_frame(3, 32'h0000_0321, 7'b0000010, 8'd9, 1'b0, "basic");
    tick();
    chk("basic_done_pulse", done, 0);

    run_frame(3, 32'h0000_0321, 7'b0000010, 8'd9, 1'b1, "bp");
    // back-to-back: start during the done cycle
    run_frame(1, 32'h0000_0007, 7'b0000000, 8'd7, 1'b0, "single");
    run_frame(4, 32'h0000_9999, 7'b0000111, 8'd161, 1'b0, "wrap");

    reject(2, 32'h0000_00A3, 8'd161, "rej_bcd");
    reject(0, 32'h0000_0011, 8'd161, "rej_zero");
    reject(9, 32'h1111_1111, 8'd161, "rej_big");

    // clear after the second character has been presented
    nterms = 4'd3; digits = 32'h0000_0321; ops = 7'b0000010; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("clr_mid_char", out, 8'h2B);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_res", res, 8'h00);
    tick();
    chk("clr_no_done", done, 0);
    run_frame(3, 32'h0000_0321, 7'b0000010, 8'd9, 1'b0, "after_clr");
    tick();

    clr = 1'b1; start = 1'b1; nterms = 4'd2; digits = 32'h0000_0055;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", busy, 0);
    chk("clr_start_valid", out_valid, 0);
    tick();
    chk("clr_start_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_tx.md
# expr_tx

Expression-string transmitter for the character-stream lab datapath. It takes a packed list of BCD operands and +/* operators and serializes them as an ASCII character stream of the form digit (op digit)*, one character per accepted handshake. It also returns the left-to-right evaluated result. It is the producer side of the expression-string checker: its output feeds the checker's 8-bit `in` port directly, either on the bench or in the loopback top.

## Interface
- MAXTERMS, 8, maximum number of operands per frame; legal range 2..15.
- clk  input  1  rising-edge clock, the only clock.
- clr  input  1  reset; synchronous, active-high.
- start  input  1  request to send one frame; sampled only in IDLE.
- nterms  input  4  number of operands in the frame; legal range 1..MAXTERMS.
- digits  input  4*MAXTERMS  BCD operands; term i occupies digits[4i+3:4i].
- ops  input  MAXTERMS-1  operator between term i and term i+1; 0 = '+' (8'h2B), 1 = '*' (8'h2A).
- out  output  8  ASCII character.
- out_valid  output  1  out holds a character.
- out_ready  input  1  consumer accepts the character this cycle.
- last  output  1  the current character is the final character of the frame.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final character is accepted.
- err  output  1  one-cycle pulse when a start request is rejected.
- res  output  8  evaluated frame value in binary (not ASCII); valid from the done pulse until the next accepted start.

## Operation
- States:
  - IDLE: waiting for start.
  - DIGIT: presenting an operand character.
  - OP: presenting an operator character.
- On start in IDLE:
  - digits, ops and nterms are latched into internal registers. Later changes to these inputs do not affect the frame in flight.
  - A start outside IDLE is ignored.
- Validation at start:
  - The request is rejected if nterms==0, nterms>MAXTERMS, or any term with index < nterms is greater than 9.
  - On rejection: err pulses, the block stays in IDLE, no character is emitted, and res is unchanged.
- Character sequence for term i:
  - DIGIT sends "0"+d_i.
  - If i < nterms-1, the block moves to OP and sends ops[i]. Otherwise the frame ends.
- Handshake:
  - A character transfers on a cycle where out_valid && out_ready.
  - While out_valid && !out_ready, out and last hold stable.
  - out_valid never drops until the character transfers.
  - DIGIT→OP, OP→DIGIT and final→IDLE transitions occur only on transfer.
- last is asserted only with the final digit.
- Evaluation:
  - Strictly left to right, no precedence: acc = d_0; then acc = acc op d_i.
  - All arithmetic is 8-bit with wrap-around (mod 256).
  - acc updates on each digit transfer. res takes acc when done pulses.
- clr, at any time including mid-frame: on the next edge the block returns to IDLE and the frame is abandoned with no done pulse.
- Reset values: out=8'h00, out_valid=0, last=0, busy=0, done=0, err=0, res=8'h00, state=IDLE.

## Timing
- Start accepted at edge t → at edge t+1: out_valid=1, out = first digit, busy=1.
- Each transfer presents the next character at the following edge. With out_ready tied high, a frame of n terms takes 2n-1 consecutive cycles.
- Final transfer at edge k → at edge k+1: out_valid=0, busy=0, done=1, res valid.
- done lasts one cycle. A start sampled at edge k+1 is accepted, so back-to-back frames have a single-cycle gap.
- Rejected start at edge t → err=1 for one cycle at t+1; busy stays 0.
- clr and start asserted together: clr wins.
- out_ready has no effect while out_valid=0.

## Test plan
- Basic frame: nterms=3, digits 1,2,3, ops = {'+','*'}, out_ready=1 → out sequence 31,2B,32,2A,33 (hex) on 5 consecutive cycles; last only with 33; done one cycle later; res=9.
- Backpressure: same frame, out_ready toggling 1,0,0,1,… → each character held stable while ready is low; no character dropped or duplicated; res=9.
- Single term: nterms=1, d0=7 → one character 37 with last=1; no operator emitted; res=7.
- Wrap-around: nterms=4, all digits 9, all ops '*' → 39,2A,39,2A,39,2A,39; res=161 (6561 mod 256).
- Rejection: nterms=2 with d1=4'hA, then nterms=0 → err pulses each time; no out_valid; res unchanged from the prior frame.
- Reset mid-frame: assert clr after the second character → next cycle out_valid=0, busy=0, no done, res=0; a new start is then accepted normally.
